// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: two source handshakes, register-file write port and,
// when WB_BYPASS_EN is defined, the two bypass lookup ports.
interface wb_arbiter_if;
  logic        src0_valid;
  logic        src0_ready;
  logic [4:0]  src0_rd;
  logic [31:0] src0_data;

  logic        src1_valid;
  logic        src1_ready;
  logic [4:0]  src1_rd;
  logic [31:0] src1_data;

  logic        rf_write_enable;
  logic [4:0]  rf_address3;
  logic [31:0] rf_write_data;

`ifdef WB_BYPASS_EN
  logic [4:0]  byp_address1;
  logic [4:0]  byp_address2;
  logic [31:0] byp_data1;
  logic [31:0] byp_data2;
  logic        byp_hit1;
  logic        byp_hit2;

  modport slave (
    input  src0_valid, src0_rd, src0_data,
    input  src1_valid, src1_rd, src1_data,
    input  byp_address1, byp_address2,
    output src0_ready, src1_ready,
    output rf_write_enable, rf_address3, rf_write_data,
    output byp_data1, byp_data2, byp_hit1, byp_hit2
  );

  modport master (
    output src0_valid, src0_rd, src0_data,
    output src1_valid, src1_rd, src1_data,
    output byp_address1, byp_address2,
    input  src0_ready, src1_ready,
    input  rf_write_enable, rf_address3, rf_write_data,
    input  byp_data1, byp_data2, byp_hit1, byp_hit2
  );
`else
  modport slave (
    input  src0_valid, src0_rd, src0_data,
    input  src1_valid, src1_rd, src1_data,
    output src0_ready, src1_ready,
    output rf_write_enable, rf_address3, rf_write_data
  );

  modport master (
    output src0_valid, src0_rd, src0_data,
    output src1_valid, src1_rd, src1_data,
    input  src0_ready, src1_ready,
    input  rf_write_enable, rf_address3, rf_write_data
  );
`endif
endinterface

// File: rtl/wb_arbiter.sv
// Two-source writeback arbiter with src1 anti-starvation and a registered
// register-file write port. Optional bypass lookup enabled by WB_BYPASS_EN.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic          clk,
  input logic          rst_n,
  wb_arbiter_if.slave  bus
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {StPrio0, StPrio1} state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_addr_q, rf_addr_d;
  logic [31:0] rf_data_q, rf_data_d;

  logic grant0, grant1;
  logic xfer0, xfer1;

  // src1 wins when alone or when it holds priority; src0 takes everything else.
  always_comb begin
    grant1 = bus.src1_valid & (~bus.src0_valid | (state_q == StPrio1));
    grant0 = bus.src0_valid & ~grant1;
  end

  // Readies are gated by reset so nothing appears to transfer while held in reset.
  assign xfer0 = grant0 & rst_n;
  assign xfer1 = grant1 & rst_n;

  assign bus.src0_ready = xfer0;
  assign bus.src1_ready = xfer1;

  always_comb begin
    starve_d = starve_q;
    if (!bus.src1_valid || xfer1) begin
      starve_d = 4'd0;
    end else if (starve_q < Limit) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPrio0: if (starve_d == Limit) state_d = StPrio1;
      StPrio1: if (xfer1)             state_d = StPrio0;
      default:                        state_d = StPrio0;
    endcase
  end

  // Address/data follow every transfer; x0 writes are suppressed via enable only.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (xfer1) begin
      rf_we_d   = (bus.src1_rd != 5'd0);
      rf_addr_d = bus.src1_rd;
      rf_data_d = bus.src1_data;
    end else if (xfer0) begin
      rf_we_d   = (bus.src0_rd != 5'd0);
      rf_addr_d = bus.src0_rd;
      rf_data_d = bus.src0_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StPrio0;
      starve_q  <= 4'd0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= 5'd0;
      rf_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign bus.rf_write_enable = rf_we_q;
  assign bus.rf_address3     = rf_addr_q;
  assign bus.rf_write_data   = rf_data_q;

`ifdef WB_BYPASS_EN
  logic hit1, hit2;

  always_comb begin
    hit1 = rf_we_q & (bus.byp_address1 == rf_addr_q) & (bus.byp_address1 != 5'd0);
    hit2 = rf_we_q & (bus.byp_address2 == rf_addr_q) & (bus.byp_address2 != 5'd0);
  end

  assign bus.byp_hit1  = hit1;
  assign bus.byp_hit2  = hit2;
  assign bus.byp_data1 = hit1 ? rf_data_q : 32'd0;
  assign bus.byp_data2 = hit2 ? rf_data_q : 32'd0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (STARVE_LIMIT = 3); bypass vectors run only
// when WB_BYPASS_EN is defined.
module tb_wb_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  wb_arbiter_if bus ();

  wb_arbiter #(
    .STARVE_LIMIT (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive_src0(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.src0_valid = v;
    bus.src0_rd    = rd;
    bus.src0_data  = d;
  endtask

  task automatic drive_src1(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.src1_valid = v;
    bus.src1_rd    = rd;
    bus.src1_data  = d;
  endtask

  // Both sources valid for four cycles from a cleared starve counter:
  // src0 wins three times, src1 on the fourth.
  task automatic starve_run(input string tag);
    logic [31:0] d0;
    d0 = 32'h200;
    drive_src0(1'b1, 5'd3, d0);
    drive_src1(1'b1, 5'd4, 32'hC1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("%s_r0_%0d", tag, i), 32'(bus.src0_ready), 32'(i != 3));
      check($sformatf("%s_r1_%0d", tag, i), 32'(bus.src1_ready), 32'(i == 3));
      @(negedge clk);
      if (i != 3) begin
        d0 = d0 + 32'd1;
        bus.src0_data = d0;
      end
    end
    check($sformatf("%s_wa", tag), 32'(bus.rf_address3), 32'd4);
    drive_src0(1'b0, 5'd0, 32'd0);
    drive_src1(1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] d0, d1;
    logic        g1;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive_src0(1'b1, 5'd9, 32'h1111);
    drive_src1(1'b1, 5'd10, 32'h2222);
`ifdef WB_BYPASS_EN
    bus.byp_address1 = 5'd0;
    bus.byp_address2 = 5'd0;
`endif

    // Reset state, with both sources asserting valid.
    #12;
    check("rst_we",    32'(bus.rf_write_enable), 32'd0);
    check("rst_addr",  32'(bus.rf_address3),     32'd0);
    check("rst_data",  bus.rf_write_data,        32'd0);
    check("rst_rdy0",  32'(bus.src0_ready),      32'd0);
    check("rst_rdy1",  32'(bus.src1_ready),      32'd0);
    @(negedge clk);
    drive_src0(1'b0, 5'd0, 32'd0);
    drive_src1(1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_we", 32'(bus.rf_write_enable), 32'd0);

    // src0 alone.
    drive_src0(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("a_rdy0", 32'(bus.src0_ready), 32'd1);
    check("a_rdy1", 32'(bus.src1_ready), 32'd0);
    @(negedge clk);
    check("a_we",   32'(bus.rf_write_enable), 32'd1);
    check("a_addr", 32'(bus.rf_address3),     32'd5);
    check("a_data", bus.rf_write_data,        32'hDEADBEEF);
    drive_src0(1'b0, 5'd0, 32'd0);
    #1;
    check("a_norun", 32'(bus.src0_ready), 32'd0);
    @(negedge clk);
    check("a_we_off",  32'(bus.rf_write_enable), 32'd0);
    check("a_hold_ad", 32'(bus.rf_address3),     32'd5);
    check("a_hold_d",  bus.rf_write_data,        32'hDEADBEEF);

    // src1 alone writing x0.
    drive_src1(1'b1, 5'd0, 32'h1234);
    #1;
    check("c_rdy1", 32'(bus.src1_ready), 32'd1);
    @(negedge clk);
    check("c_we",   32'(bus.rf_write_enable), 32'd0);
    check("c_addr", 32'(bus.rf_address3),     32'd0);
    check("c_data", bus.rf_write_data,        32'h1234);
    drive_src1(1'b0, 5'd0, 32'd0);
    @(negedge clk);

    // Both valid continuously: grants 0,0,0,1,0,0.
    d0 = 32'h100;
    d1 = 32'hB1;
    drive_src0(1'b1, 5'd1, d0);
    drive_src1(1'b1, 5'd2, d1);
    for (int i = 0; i < 6; i++) begin
      g1 = (i == 3);
      #1;
      check($sformatf("b_r0_%0d", i), 32'(bus.src0_ready), 32'(!g1));
      check($sformatf("b_r1_%0d", i), 32'(bus.src1_ready), 32'(g1));
      @(negedge clk);
      check($sformatf("b_we_%0d", i), 32'(bus.rf_write_enable), 32'd1);
      check($sformatf("b_ad_%0d", i), 32'(bus.rf_address3), g1 ? 32'd2 : 32'd1);
      check($sformatf("b_d_%0d", i),  bus.rf_write_data, g1 ? d1 : d0);
      if (g1) d1 = 32'hB2;
      else    d0 = d0 + 32'd1;
      bus.src0_data = d0;
      bus.src1_data = d1;
    end
    drive_src0(1'b0, 5'd0, 32'd0);
    drive_src1(1'b0, 5'd0, 32'd0);
    @(negedge clk);

    // Mid-cycle reset with both valid after two stalled src1 cycles.
    drive_src0(1'b1, 5'd6, 32'hA0);
    drive_src1(1'b1, 5'd8, 32'hB0);
    @(negedge clk);
    @(negedge clk);
    check("r_pre_we", 32'(bus.rf_write_enable), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_rdy0", 32'(bus.src0_ready),      32'd0);
    check("r_rdy1", 32'(bus.src1_ready),      32'd0);
    check("r_we",   32'(bus.rf_write_enable), 32'd0);
    check("r_addr", 32'(bus.rf_address3),     32'd0);
    check("r_data", bus.rf_write_data,        32'd0);
    @(negedge clk);
    check("r_held_we", 32'(bus.rf_write_enable), 32'd0);
    drive_src0(1'b0, 5'd0, 32'd0);
    drive_src1(1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("r_post_we",   32'(bus.rf_write_enable), 32'd0);
    check("r_post_addr", 32'(bus.rf_address3),     32'd0);
    // Starve counter and FSM must have restarted from zero.
    starve_run("s");

`ifdef WB_BYPASS_EN
    @(negedge clk);
    drive_src0(1'b1, 5'd7, 32'h55AA);
    bus.byp_address1 = 5'd7;
    bus.byp_address2 = 5'd0;
    @(negedge clk);
    drive_src0(1'b0, 5'd0, 32'd0);
    check("byp_hit1",  32'(bus.byp_hit1), 32'd1);
    check("byp_data1", bus.byp_data1,     32'h55AA);
    check("byp_hit2",  32'(bus.byp_hit2), 32'd0);
    check("byp_data2", bus.byp_data2,     32'd0);
    @(negedge clk);
    check("byp_stale", 32'(bus.byp_hit1), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
